// File: rtl/dmem_responder.sv
// Single-port RV32I data-memory responder: one request at a time, valid/ready
// handshakes on both sides, byte/half/word access with load extension.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_rdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LA_W  = IDX_W + 2;
    localparam logic [AW:0] LIMIT = (AW+1)'(4 * DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                     input logic [AW-1:0] a);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = a[0];
            3'b010:         bad = (a[1:0] != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad | (we & f3[2]) | ~in_range(a);
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Only the addressed byte lanes take new data; the rest keep the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] mask;
        case (size)
            2'b00: begin
                be   = 4'b0001 << lane;
                data = {4{wd[7:0]}};
            end
            2'b01: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                data = {2{wd[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                data = wd;
            end
        endcase
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [LA_W-1:0]  addr_r;
    logic             we_r;
    logic [2:0]       funct3_r;
    logic [31:0]      wdata_r;
    logic             req_ready_r;
    logic             resp_valid_r;
    logic             resp_err_r;
    logic [31:0]      resp_rdata_r;
    logic             accept_s;
    logic [IDX_W-1:0] word_idx_s;
    logic [31:0]      mem_word_s;
    logic [31:0]      dbg_rdata_s;
    logic [31:0]      mem_r [DEPTH];

    assign accept_s   = req_valid & req_ready_r;
    assign word_idx_s = addr_r[LA_W-1:2];
    assign mem_word_s = mem_r[word_idx_s];

    // Next-state decode for the request/response sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_bad(req_we, req_funct3, req_addr)) begin
                        state_nx_s = ERR;
                    end else if (req_we) begin
                        state_nx_s = WRITE;
                    end else begin
                        state_nx_s = READ;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            READ, WRITE, ERR: state_nx_s = RESP;
            RESP: begin
                if (resp_valid_r && resp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Sequencer state, request capture and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            addr_r       <= {LA_W{1'b0}};
            we_r         <= 1'b0;
            funct3_r     <= 3'd0;
            wdata_r      <= 32'd0;
        end else begin
            state_r     <= state_nx_s;
            req_ready_r <= (state_nx_s == IDLE);
            if (accept_s) begin
                addr_r   <= req_addr[LA_W-1:0];
                we_r     <= req_we;
                funct3_r <= req_funct3;
                wdata_r  <= req_wdata;
            end
            case (state_r)
                READ:  resp_rdata_r <= load_extract(mem_word_s, addr_r[1:0], funct3_r);
                WRITE: resp_rdata_r <= 32'd0;
                ERR: begin
                    resp_err_r   <= 1'b1;
                    resp_rdata_r <= 32'd0;
                end
                RESP: begin
                    // valid rises one cycle into RESP, so the next accept is >= 4 edges on
                    if (!resp_valid_r) begin
                        resp_valid_r <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'd0;
                    end
                end
                default: resp_valid_r <= resp_valid_r;
            endcase
        end
    end

    // Data array; deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (state_r == WRITE && we_r) begin
            mem_r[word_idx_s] <= store_merge(mem_word_s, addr_r[1:0], funct3_r[1:0], wdata_r);
        end
    end

    // Debug word port; reads zero outside the array.
    always_comb begin
        dbg_rdata_s = 32'd0;
        if (in_range(dbg_addr)) begin
            dbg_rdata_s = mem_r[dbg_addr[LA_W-1:2]];
        end else begin
            dbg_rdata_s = 32'd0;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    assign dbg_rdata  = dbg_rdata_s;

endmodule
